// File: rtl/dnn_train_scheduler_if.sv
// Bus between the training scheduler and its environment: run control,
// DNN output comparison inputs, mux selects and run statistics.
interface dnn_train_scheduler_if #(
    parameter int cpc            = 6,
    parameter int training_cases = 8,
    parameter int out_w          = 1,
    parameter int err_w          = 16
);
    localparam int TC_W = (training_cases > 1) ? $clog2(training_cases) : 1;
    localparam int SN_W = (cpc > 3) ? $clog2(cpc - 2) : 1;
    localparam int CI_W = $clog2(cpc);

    logic              start;
    logic              abort;
    logic [out_w-1:0]  a_out;
    logic [out_w-1:0]  y_out;
    logic              busy;
    logic              done;
    logic [TC_W-1:0]   sel_tc;
    logic [SN_W-1:0]   sel_network;
    logic [CI_W-1:0]   cycle_index;
    logic              case_start;
    logic              case_done;
    logic              case_err;
    logic [31:0]       num_train;
    logic [err_w-1:0]  total_error;

    modport master (
        output start, abort, a_out, y_out,
        input  busy, done, sel_tc, sel_network, cycle_index,
               case_start, case_done, case_err, num_train, total_error
    );

    modport slave (
        input  start, abort, a_out, y_out,
        output busy, done, sel_tc, sel_network, cycle_index,
               case_start, case_done, case_err, num_train, total_error
    );
endinterface

// File: rtl/dnn_train_scheduler.sv
// Start/abort controlled sequencer that walks the DNN through cpc-cycle
// training-case blocks and accumulates a saturating per-case error count.
module dnn_train_scheduler #(
    parameter int cpc            = 6,
    parameter int training_cases = 8,
    parameter int out_w          = 1,
    parameter int max_cases      = 1000,
    parameter int err_w          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    dnn_train_scheduler_if.slave     bus
);
    localparam int TC_W = (training_cases > 1) ? $clog2(training_cases) : 1;
    localparam int SN_W = (cpc > 3) ? $clog2(cpc - 2) : 1;
    localparam int CI_W = $clog2(cpc);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [TC_W-1:0]   r_sel_tc;
    logic [CI_W-1:0]   r_cycle_index;
    logic              r_case_start;
    logic              r_case_done;
    logic              r_case_err;
    logic              r_tc_error;
    logic [31:0]       r_num_train;
    logic [err_w-1:0]  r_total_error;

    logic              w_ci_last;
    logic              w_mismatch;
    logic              w_case_err;
    logic              w_last_case;
    logic [TC_W-1:0]   w_sel_tc_next;
    logic [SN_W-1:0]   w_sel_network;

    function automatic logic [err_w-1:0] sat_add(input logic [err_w-1:0] v, input logic inc);
        if (inc && (v != {err_w{1'b1}})) begin
            return v + err_w'(1);
        end else begin
            return v;
        end
    endfunction

    // The first two cycles of a block are pipeline fill, so they never count as errors.
    assign w_ci_last     = (r_cycle_index == CI_W'(cpc - 1));
    assign w_mismatch    = (r_state == ST_RUN) && (r_cycle_index >= CI_W'(2)) &&
                           (bus.a_out != bus.y_out);
    assign w_case_err    = r_tc_error | w_mismatch;
    assign w_last_case   = ((r_num_train + 32'd1) == 32'(max_cases));
    assign w_sel_tc_next = (r_sel_tc == TC_W'(training_cases - 1)) ? {TC_W{1'b0}}
                                                                   : r_sel_tc + TC_W'(1);

    // Feed slices are presented in reverse order during the first cpc-2 cycles.
    always_comb begin
        w_sel_network = {SN_W{1'b0}};
        if ((r_state == ST_RUN) && (r_cycle_index < CI_W'(cpc - 2))) begin
            w_sel_network = SN_W'(cpc - 3) - SN_W'(r_cycle_index);
        end else begin
            w_sel_network = {SN_W{1'b0}};
        end
    end

    // Run-control FSM with all registered outputs and statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_sel_tc      <= {TC_W{1'b0}};
            r_cycle_index <= {CI_W{1'b0}};
            r_case_start  <= 1'b0;
            r_case_done   <= 1'b0;
            r_case_err    <= 1'b0;
            r_tc_error    <= 1'b0;
            r_num_train   <= 32'd0;
            r_total_error <= {err_w{1'b0}};
        end else begin
            r_case_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (bus.start) begin
                        r_state       <= ST_RUN;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_case_start  <= 1'b1;
                        r_cycle_index <= {CI_W{1'b0}};
                        r_sel_tc      <= {TC_W{1'b0}};
                        r_num_train   <= 32'd0;
                        r_total_error <= {err_w{1'b0}};
                        r_tc_error    <= 1'b0;
                        r_case_err    <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        // Partial case is dropped without touching the statistics.
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_case_start <= 1'b0;
                    end else if (w_ci_last) begin
                        r_case_err    <= w_case_err;
                        r_case_done   <= 1'b1;
                        r_total_error <= sat_add(r_total_error, w_case_err);
                        r_num_train   <= r_num_train + 32'd1;
                        r_sel_tc      <= w_sel_tc_next;
                        r_tc_error    <= 1'b0;
                        r_cycle_index <= {CI_W{1'b0}};
                        if (w_last_case) begin
                            r_state      <= ST_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_case_start <= 1'b0;
                        end else begin
                            r_state      <= ST_RUN;
                            r_case_start <= 1'b1;
                        end
                    end else begin
                        r_cycle_index <= r_cycle_index + CI_W'(1);
                        r_tc_error    <= w_case_err;
                        r_case_start  <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                    r_case_start <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sel_tc      = r_sel_tc;
    assign bus.sel_network = w_sel_network;
    assign bus.cycle_index = r_cycle_index;
    assign bus.case_start  = r_case_start;
    assign bus.case_done   = r_case_done;
    assign bus.case_err    = r_case_err;
    assign bus.num_train   = r_num_train;
    assign bus.total_error = r_total_error;
endmodule

// File: tb/tb_dnn_train_scheduler.sv
// Directed bench: instance A (8 cases, 16-bit error) and instance B
// (5 stored cases, 2-bit saturating error) share clock and reset.
module tb_dnn_train_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    always #5 clk = ~clk;

    dnn_train_scheduler_if #(.cpc(6), .training_cases(8), .out_w(1), .err_w(16)) ifa ();
    dnn_train_scheduler_if #(.cpc(6), .training_cases(5), .out_w(1), .err_w(2))  ifb ();

    dnn_train_scheduler #(.cpc(6), .training_cases(8), .out_w(1), .max_cases(8), .err_w(16))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    dnn_train_scheduler #(.cpc(6), .training_cases(5), .out_w(1), .max_cases(8), .err_w(2))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        chk({tag, "_done"}, 32'(ifa.done), 32'd0);
        chk({tag, "_sel_tc"}, 32'(ifa.sel_tc), 32'd0);
        chk({tag, "_ci"}, 32'(ifa.cycle_index), 32'd0);
        chk({tag, "_cs"}, 32'(ifa.case_start), 32'd0);
        chk({tag, "_cd"}, 32'(ifa.case_done), 32'd0);
        chk({tag, "_ce"}, 32'(ifa.case_err), 32'd0);
        chk({tag, "_num"}, ifa.num_train, 32'd0);
        chk({tag, "_tot"}, 32'(ifa.total_error), 32'd0);
        chk({tag, "_sn"}, 32'(ifa.sel_network), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.a_out = 1'b0; ifa.y_out = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.a_out = 1'b1; ifb.y_out = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        chk_idle_zero("rst");
        chk("rst_b_busy", 32'(ifb.busy), 32'd0);
        chk("rst_b_tot", 32'(ifb.total_error), 32'd0);

        // Run of 8 clean cases; a start pulse mid-run must be ignored.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        for (int j = 0; j < 48; j++) begin
            chk("run_ci", 32'(ifa.cycle_index), 32'(j % 6));
            chk("run_sel_tc", 32'(ifa.sel_tc), 32'(j / 6));
            chk("run_busy", 32'(ifa.busy), 32'd1);
            chk("run_cd", 32'(ifa.case_done), ((j % 6 == 0) && (j != 0)) ? 32'd1 : 32'd0);
            if (j < 7) begin
                chk("run_sn", 32'(ifa.sel_network), (j % 6 < 4) ? 32'(3 - j % 6) : 32'd0);
                chk("run_cs", 32'(ifa.case_start), (j % 6 == 0) ? 32'd1 : 32'd0);
            end
            if (ifa.case_done) begin
                n_done++;
                chk("run_ce", 32'(ifa.case_err), 32'd0);
            end
            ifa.start = (j == 20) ? 1'b1 : 1'b0;
            tick();
        end
        ifa.start = 1'b0;
        if (ifa.case_done) n_done++;
        chk("done_flag", 32'(ifa.done), 32'd1);
        chk("done_busy", 32'(ifa.busy), 32'd0);
        chk("done_num", ifa.num_train, 32'd8);
        chk("done_tot", 32'(ifa.total_error), 32'd0);
        chk("done_pulses", 32'(n_done), 32'd8);
        chk("done_sn", 32'(ifa.sel_network), 32'd0);
        tick();
        chk("done_hold", 32'(ifa.done), 32'd1);
        chk("done_cd_pulse", 32'(ifa.case_done), 32'd0);
        chk("done_num_hold", ifa.num_train, 32'd8);

        // Restart from DONE, then mismatch inside and outside the check window.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("rs_busy", 32'(ifa.busy), 32'd1);
        chk("rs_num", ifa.num_train, 32'd0);
        chk("rs_done", 32'(ifa.done), 32'd0);
        chk("rs_cs", 32'(ifa.case_start), 32'd1);
        tick();
        ifa.a_out = 1'b1;
        tick();
        ifa.a_out = 1'b0;
        repeat (4) tick();
        chk("mm1_cd", 32'(ifa.case_done), 32'd1);
        chk("mm1_ce", 32'(ifa.case_err), 32'd0);
        chk("mm1_num", ifa.num_train, 32'd1);
        repeat (5) tick();
        chk("mm5_ci", 32'(ifa.cycle_index), 32'd5);
        ifa.a_out = 1'b1;
        tick();
        ifa.a_out = 1'b0;
        chk("mm5_cd", 32'(ifa.case_done), 32'd1);
        chk("mm5_ce", 32'(ifa.case_err), 32'd1);
        chk("mm5_tot", 32'(ifa.total_error), 32'd1);
        chk("mm5_num", ifa.num_train, 32'd2);
        chk("mm5_sel_tc", 32'(ifa.sel_tc), 32'd2);

        // Abort mid-case.
        repeat (3) tick();
        chk("ab3_ci", 32'(ifa.cycle_index), 32'd3);
        ifa.abort = 1'b1;
        tick();
        ifa.abort = 1'b0;
        chk("ab3_busy", 32'(ifa.busy), 32'd0);
        chk("ab3_cd", 32'(ifa.case_done), 32'd0);
        chk("ab3_num", ifa.num_train, 32'd2);
        chk("ab3_tot", 32'(ifa.total_error), 32'd1);
        chk("ab3_sn", 32'(ifa.sel_network), 32'd0);
        chk("ab3_ce_hold", 32'(ifa.case_err), 32'd1);
        tick();
        chk("ab3_cd2", 32'(ifa.case_done), 32'd0);

        // start together with abort in IDLE does nothing.
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        chk("sa_busy", 32'(ifa.busy), 32'd0);
        chk("sa_num", ifa.num_train, 32'd2);
        tick();
        chk("sa_busy2", 32'(ifa.busy), 32'd0);

        // Abort on the final cycle of a case with a live mismatch.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        chk("ab5_ce_clr", 32'(ifa.case_err), 32'd0);
        repeat (5) tick();
        chk("ab5_ci", 32'(ifa.cycle_index), 32'd5);
        ifa.a_out = 1'b1;
        ifa.abort = 1'b1;
        tick();
        ifa.a_out = 1'b0;
        ifa.abort = 1'b0;
        chk("ab5_busy", 32'(ifa.busy), 32'd0);
        chk("ab5_cd", 32'(ifa.case_done), 32'd0);
        chk("ab5_num", ifa.num_train, 32'd0);
        chk("ab5_tot", 32'(ifa.total_error), 32'd0);

        // Reset in the middle of the second case.
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (2) tick();
        ifa.a_out = 1'b1;
        tick();
        ifa.a_out = 1'b0;
        repeat (3) tick();
        chk("pre_rst_ce", 32'(ifa.case_err), 32'd1);
        chk("pre_rst_tot", 32'(ifa.total_error), 32'd1);
        chk("pre_rst_sel_tc", 32'(ifa.sel_tc), 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_zero("mid_rst");
        tick();
        chk("post_rst_busy", 32'(ifa.busy), 32'd0);

        // Instance B: every case erroneous, sel_tc wraps at 5, total saturates at 3.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        for (int j = 0; j < 48; j++) begin
            chk("b_busy", 32'(ifb.busy), 32'd1);
            if (j % 6 == 0) begin
                chk("b_sel_tc", 32'(ifb.sel_tc), 32'((j / 6) % 5));
                if (j > 0) begin
                    chk("b_ce", 32'(ifb.case_err), 32'd1);
                    chk("b_tot", 32'(ifb.total_error), (j / 6 < 3) ? 32'(j / 6) : 32'd3);
                end
            end
            tick();
        end
        chk("b_done", 32'(ifb.done), 32'd1);
        chk("b_tot_sat", 32'(ifb.total_error), 32'd3);
        chk("b_num", ifb.num_train, 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dnn_train_scheduler.md
Name: dnn_train_scheduler

Overview:
- Synthesizable sequencer that drives the DNN through a run of training cases.
- Each case occupies one cpc-cycle block. Per block it generates the training-case select, the per-cycle feed-slice select and the block cycle index.
- It compares actual against ideal outputs, flags per-case errors and accumulates a saturating error total until max_cases cases are done.
- Sits between the training-data mux tree and the DNN, and replaces free-running cycle counting with a start/abort/done controlled run.

Parameters:
- cpc, 6, cycles per training case (feed slices + 2).
- training_cases, 8, number of stored training cases; values that are not a power of two are legal.
- out_w, 1, output neurons per clock (width of a_out/y_out).
- max_cases, 1000, cases processed before done.
- err_w, 16, width of total_error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  level/pulse; starts a run when sampled in IDLE or DONE.
- abort  in  1  ends a run at the next edge.
- a_out  in  out_w  DNN actual output.
- y_out  in  out_w  DNN ideal output, already delayed through the DNN.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- sel_tc  out  $clog2(training_cases)  training-case mux select.
- sel_network  out  $clog2(cpc-2)  feed-slice mux select.
- cycle_index  out  $clog2(cpc)  position within the current block.
- case_start  out  1  high when cycle_index==0 in RUN.
- case_done  out  1  one-cycle pulse after a case finishes.
- case_err  out  1  error flag of the last finished case; valid with case_done and held afterwards.
- num_train  out  32  cases completed in this run.
- total_error  out  err_w  erroneous cases in this run.

Behaviour:
- Clock and reset: single clock domain. All state changes on posedge clk. reset is synchronous and active-high and overrides all other inputs.
- Reset values: state=IDLE, busy=0, done=0, sel_tc=0, cycle_index=0, case_start=0, case_done=0, case_err=0, num_train=0, total_error=0, internal tc_error=0.
- States: IDLE, RUN, DONE.
- IDLE: start && !abort -> RUN next edge. On entry, clear cycle_index, sel_tc, num_train, total_error, tc_error and case_err. start && abort -> stay in IDLE.
- RUN, cycle index: cycle_index increments each cycle and wraps cpc-1 -> 0.
- RUN, feed select: sel_network = cpc-3-cycle_index when cycle_index < cpc-2; otherwise 0. This output is combinational from cycle_index.
- RUN, error check: mismatch = (cycle_index >= 2) && (a_out != y_out). Any mismatch sets tc_error.
- RUN, case end: at the edge leaving cycle_index==cpc-1:
  - case_err <= tc_error | mismatch, and case_done pulses for the next cycle;
  - total_error <= total_error + that flag, saturating at 2^err_w-1;
  - num_train++;
  - sel_tc <= (sel_tc==training_cases-1) ? 0 : sel_tc+1;
  - tc_error <= 0.
- RUN -> DONE: at that same edge when num_train+1 == max_cases. cycle_index and sel_tc then hold their values.
- Abort: abort in RUN -> IDLE next edge. A partial case is discarded: no case_done, num_train and total_error hold. Abort has priority over a case end in the same cycle.
- start in RUN is ignored.
- DONE: done=1, busy=0, all counters hold. start -> RUN with the same clears as from IDLE. abort -> IDLE.
- Outside RUN: case_start=0 and sel_network=0.
- Reset mid-run returns to IDLE with all values at their reset values on the next edge.

Test Plan:
- Reset held for 9 cycles, then release -> all outputs 0, state IDLE; start pulse -> busy=1 next cycle, cycle_index sequence 0,1,2,3,4,5,0; sel_network 3,2,1,0,0,0; case_start high only at index 0.
- a_out tied equal to y_out, max_cases=8 -> 8 case_done pulses each with case_err=0; sel_tc counts 0..7; done=1 after 48 cycles; total_error=0; num_train=8.
- Single mismatch injected at cycle_index=1 of case 0 -> case_err=0 (window excluded). Mismatch at cycle_index=5 of case 1 -> case_err=1 and total_error=1.
- training_cases=5 -> sel_tc wraps 0,1,2,3,4,0. With err_w=2 and all cases erroneous, total_error saturates at 3.
- abort asserted at cycle_index=3 of case 2 -> IDLE next cycle, num_train=2, no case_done. abort coinciding with cycle_index=5 -> no case_done, num_train unchanged.
- start in DONE -> counters cleared and a new run begins. start && abort in IDLE -> stays IDLE. reset at mid-case -> all outputs 0 next cycle.
